poly_square: RTL and testbench

- Sequential fixed-point squarer; the inverse of the piecewise-linear square-root stage in the noise generator datapath.
- Maps a u4.13 magnitude (the format the sqrt stage produces) back to the u7.24 domain the sqrt stage consumes.
- Uses a bit-serial shift-add multiplier with valid/ready handshakes on both sides.
- Used for round-trip checking of the sqrt stage and for variance/energy computation on noise samples.

---
 rtl/poly_square.sv | 76 +++++++
 tb/tb_poly_square.sv | 122 ++++++++++++
 2 files changed

// File: rtl/poly_square.sv
// poly_square: bit-serial shift-add squarer, u4.13 magnitude back to the u7.24 domain
// Saturates to all ones when the scaled square does not fit in OUT_W bits.
module poly_square #(
   parameter int IN_W     = 17,
   parameter int IN_FRAC  = 13,
   parameter int OUT_W    = 31,
   parameter int OUT_FRAC = 24
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_sat,
   output logic             busy
);
   localparam int PW = 2*IN_W;
   localparam int SH = 2*IN_FRAC - OUT_FRAC;
   localparam int CW = $clog2(IN_W + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t          state;
   logic [PW-1:0]   mcand, acc, acc_nxt, r;
   logic [IN_W-1:0] mplier;
   logic [CW-1:0]   count;
   logic            sat;
   assign in_ready = state == IDLE;
   // multiplicand and multiplier shift in lockstep, so mplier[0] is bit[count]
   assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
   assign r        = acc_nxt >> SH;
   assign sat      = |(r >> OUT_W);
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               mcand  <= {{IN_W{1'b0}}, in_data};
               mplier <= in_data;
               acc    <= '0;
               count  <= '0;
               busy   <= 1'b1;
               state  <= BUSY;
            end
            BUSY: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + CW'(1);
               if (count == CW'(IN_W - 1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  out_sat   <= sat;
                  out_data  <= sat ? '1 : r[OUT_W-1:0];
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_poly_square.sv
// tb_poly_square: directed vectors with hand-computed squares for poly_square
module tb_poly_square;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [16:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [30:0] out_data;
   logic        out_sat;
   logic        busy;
   int          checks = 0;
   int          errors = 0;
   logic [30:0] held;

   poly_square dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic op(input string tag, input logic [16:0] x, input logic [30:0] ed,
                     input logic es, input logic ordy);
      int n;
      @(negedge clock);
      chk({tag, "_in_ready"}, in_ready, 1);
      in_valid  = 1'b1;
      in_data   = x;
      out_ready = ordy;
      @(posedge clock); #1;
      in_valid = 1'b0;
      in_data  = ~x;
      n = 1;
      chk({tag, "_busy"}, busy, 1);
      while (!out_valid && n < 40) begin
         @(posedge clock); #1;
         n++;
      end
      chk({tag, "_latency"}, n, 18);
      chk({tag, "_data"}, out_data, ed);
      chk({tag, "_sat"}, out_sat, es);
      chk({tag, "_busy_done"}, busy, 0);
      if (ordy) begin
         @(posedge clock); #1;
         chk({tag, "_valid_clr"}, out_valid, 0);
         chk({tag, "_idle"}, in_ready, 1);
      end
   endtask

   initial begin
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", out_data, 0);
      chk("rst_sat", out_sat, 0);
      @(negedge clock) reset = 1'b1;

      op("one",   17'h02000, 31'h1000000,  1'b0, 1'b1);
      op("two5",  17'h05000, 31'h6400000,  1'b0, 1'b1);
      op("near",  17'h16A00, 31'h7FF90000, 1'b0, 1'b1);
      op("lsb",   17'h00001, 31'h0,        1'b0, 1'b1);
      op("trunc", 17'h00003, 31'h2,        1'b0, 1'b1);
      op("zero",  17'h00000, 31'h0,        1'b0, 1'b1);
      op("max",   17'h1FFFF, 31'h7FFFFFFF, 1'b1, 1'b1);
      op("over",  17'h16A0A, 31'h7FFFFFFF, 1'b1, 1'b1);

      // backpressure: result must hold and a stray operand must be ignored
      op("bp", 17'h05000, 31'h6400000, 1'b0, 1'b0);
      held = out_data;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         in_valid = (i == 4);
         in_data  = 17'h1FFFF;
         chk("bp_stable", out_data, held);
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      @(negedge clock);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_idle", in_ready, 1);
      chk("bp_release_busy", busy, 0);
      op("after_bp", 17'h00003, 31'h2, 1'b0, 1'b1);

      // reset with count at 8
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = 17'h16A00;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_data", out_data, 0);
      @(negedge clock) reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
      op("post_rst", 17'h02000, 31'h1000000, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
